// File: rtl/sfp_link_pkg.sv
// Shared constants, FSM state types and the CRC16-CCITT word step for the SFP frame link.
package sfp_link_pkg;

    localparam logic [31:0] SFP_HDR         = 32'h5AA5_000C;
    localparam logic [15:0] SFP_TRL_SYNC    = 16'hA55A;
    localparam int          SFP_FRAME_WORDS = 12;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_HDR  = 2'd1,
        TX_DATA = 2'd2,
        TX_TRL  = 2'd3
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_HUNT = 2'd0,
        RX_DATA = 2'd1,
        RX_TRL  = 2'd2
    } rx_state_e;

    // Poly 0x1021, no reflection, word consumed MSB first.
    function automatic logic [15:0] crc16_step32(input logic [15:0] crc, input logic [31:0] word);
        logic [15:0] c;
        c = crc;
        for (int i = 31; i >= 0; i--) begin
            if (c[15] ^ word[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
            else                 c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/sfp_crc16_acc.sv
// Clear/enable CRC16-CCITT accumulator (init 0xFFFF), one 32-bit word per enabled cycle.
// Only built when SFP_CRC_EN is defined.
`ifdef SFP_CRC_EN
module sfp_crc16_acc (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clr,
    input  logic        i_en,
    input  logic [31:0] i_word,
    output logic [15:0] o_crc
);
    import sfp_link_pkg::*;

    logic [15:0] r_crc;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)     r_crc <= 16'hFFFF;
        else if (i_clr) r_crc <= 16'hFFFF;
        else if (i_en)  r_crc <= crc16_step32(r_crc, i_word);
    end

    assign o_crc = r_crc;

endmodule
`endif

// File: rtl/sfp_frame_link.sv
// Frame link: serializes a 384-bit frame as header/12 words/trailer on TX, reassembles and checks on RX.
// SFP_CRC_EN defined: trailer carries and RX verifies a CRC16 over the data words.
module sfp_frame_link (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_link_up,
    input  logic [383:0] i_tx_data,
    input  logic         i_tx_start_flag,
    output logic         o_tx_end_flag,
    output logic [31:0]  o_tx_word,
    output logic         o_tx_valid,
    input  logic         i_tx_ready,
    input  logic [31:0]  i_rx_word,
    input  logic         i_rx_valid,
    output logic [383:0] o_rx_data,
    output logic         o_rx_end_flag,
    output logic [7:0]   o_rx_err_cnt,
    output logic         o_tx_busy
);
    import sfp_link_pkg::*;

    localparam logic [3:0] LAST_WORD = 4'(SFP_FRAME_WORDS - 1);

    tx_state_e    r_tx_state;
    logic [383:0] r_tx_shift;
    logic [3:0]   r_tx_cnt;
    logic         r_tx_end;
    logic [15:0]  w_tx_crc;

    rx_state_e    r_rx_state;
    logic [383:0] r_rx_stage;
    logic [3:0]   r_rx_cnt;
    logic [383:0] r_rx_data;
    logic [7:0]   r_rx_err;
    logic         r_rx_end;
    logic         w_rx_trl_ok;

`ifdef SFP_CRC_EN
    logic [15:0] w_rx_crc;

    sfp_crc16_acc u_tx_crc (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (r_tx_state == TX_IDLE),
        .i_en   ((r_tx_state == TX_DATA) && i_tx_ready),
        .i_word (r_tx_shift[383:352]),
        .o_crc  (w_tx_crc)
    );

    sfp_crc16_acc u_rx_crc (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (r_rx_state == RX_HUNT),
        .i_en   ((r_rx_state == RX_DATA) && i_rx_valid),
        .i_word (i_rx_word),
        .o_crc  (w_rx_crc)
    );

    assign w_rx_trl_ok = (i_rx_word[31:16] == SFP_TRL_SYNC) && (i_rx_word[15:0] == w_rx_crc);
`else
    assign w_tx_crc    = 16'h0000;
    assign w_rx_trl_ok = (i_rx_word[31:16] == SFP_TRL_SYNC);
`endif

    // TX: the state alone selects the outgoing word, so it holds while ready is low.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_tx_state <= TX_IDLE;
            r_tx_shift <= '0;
            r_tx_cnt   <= '0;
            r_tx_end   <= 1'b0;
        end else begin
            r_tx_end <= 1'b0;
            if (!i_link_up) begin
                r_tx_state <= TX_IDLE;
                r_tx_cnt   <= '0;
            end else begin
                case (r_tx_state)
                    TX_IDLE: if (i_tx_start_flag) begin
                        r_tx_shift <= i_tx_data;
                        r_tx_cnt   <= '0;
                        r_tx_state <= TX_HDR;
                    end
                    TX_HDR: if (i_tx_ready) r_tx_state <= TX_DATA;
                    TX_DATA: if (i_tx_ready) begin
                        r_tx_shift <= {r_tx_shift[351:0], 32'h0};
                        r_tx_cnt   <= r_tx_cnt + 4'd1;
                        if (r_tx_cnt == LAST_WORD) r_tx_state <= TX_TRL;
                    end
                    TX_TRL: if (i_tx_ready) begin
                        r_tx_state <= TX_IDLE;
                        r_tx_end   <= 1'b1;
                    end
                    default: r_tx_state <= TX_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        o_tx_word = 32'h0;
        case (r_tx_state)
            TX_HDR:  o_tx_word = SFP_HDR;
            TX_DATA: o_tx_word = r_tx_shift[383:352];
            TX_TRL:  o_tx_word = {SFP_TRL_SYNC, w_tx_crc};
            default: o_tx_word = 32'h0;
        endcase
    end

    assign o_tx_valid    = (r_tx_state != TX_IDLE);
    assign o_tx_busy     = (r_tx_state != TX_IDLE);
    assign o_tx_end_flag = r_tx_end;

    // RX: a header inside a frame is plain data; only HUNT looks for it.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_rx_state <= RX_HUNT;
            r_rx_stage <= '0;
            r_rx_cnt   <= '0;
            r_rx_data  <= '0;
            r_rx_err   <= '0;
            r_rx_end   <= 1'b0;
        end else begin
            r_rx_end <= 1'b0;
            if (!i_link_up) begin
                r_rx_state <= RX_HUNT;
                r_rx_stage <= '0;
                r_rx_cnt   <= '0;
            end else if (i_rx_valid) begin
                case (r_rx_state)
                    RX_HUNT: if (i_rx_word == SFP_HDR) begin
                        r_rx_state <= RX_DATA;
                        r_rx_cnt   <= '0;
                    end
                    RX_DATA: begin
                        r_rx_stage <= {r_rx_stage[351:0], i_rx_word};
                        r_rx_cnt   <= r_rx_cnt + 4'd1;
                        if (r_rx_cnt == LAST_WORD) r_rx_state <= RX_TRL;
                    end
                    RX_TRL: begin
                        if (w_rx_trl_ok) begin
                            r_rx_data <= r_rx_stage;
                            r_rx_end  <= 1'b1;
                        end else if (r_rx_err != 8'hFF) begin
                            r_rx_err <= r_rx_err + 8'd1;
                        end
                        r_rx_state <= RX_HUNT;
                    end
                    default: r_rx_state <= RX_HUNT;
                endcase
            end
        end
    end

    assign o_rx_data     = r_rx_data;
    assign o_rx_end_flag = r_rx_end;
    assign o_rx_err_cnt  = r_rx_err;

endmodule
